// File: rtl/int_controller_if.sv
// CPU I/O bus port of the interrupt controller: register select, strobes and data.
interface int_controller_if;
   logic [1:0] addr;
   logic       we;
   logic       re;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (output addr, output we, output re, output wdata, input rdata);
   modport slave  (input addr, input we, input re, input wdata, output rdata);
endinterface

// File: rtl/int_controller.sv
// Eight-source interrupt controller: edge-detected pending bits, software mask and
// four independent fixed-width pulse generators feeding the CPU's int1..int4 inputs.
module int_controller #(
   parameter int PULSE_W = 4,
   parameter int NSRC    = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NSRC-1:0] i_src,
   int_controller_if.slave bus,
   output logic            o_int1,
   output logic            o_int2,
   output logic            o_int3,
   output logic            o_int4
);
   localparam int CW = (PULSE_W > 2) ? $clog2(PULSE_W) : 1;
   localparam logic [CW-1:0] LOAD = CW'(PULSE_W - 1);

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

   logic [NSRC-1:0] r_srcPrev;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_mask;
   logic [7:0]      r_rdata;
   logic [3:0]      r_req;
   logic [3:0]      r_int;
   state_t          r_state [4];
   logic [CW-1:0]   r_cnt [4];
   logic [3:0]      r_queued;

   logic [NSRC-1:0] w_event;
   logic [NSRC-1:0] w_clear;
   logic [NSRC-1:0] w_maskRise;
   logic [NSRC-1:0] w_fire;
   logic [3:0]      w_req;
   logic            w_wrPend;
   logic            w_wrMask;
   state_t          w_stateNext [4];
   logic [CW-1:0]   w_cntNext [4];
   logic [3:0]      w_queuedNext;

   assign w_wrPend   = bus.we && (bus.addr == 2'd0);
   assign w_wrMask   = bus.we && (bus.addr == 2'd1);
   assign w_event    = i_src & ~r_srcPrev;
   assign w_clear    = w_wrPend ? bus.wdata : '0;
   // Unmasking an already-pending source must still interrupt the CPU.
   assign w_maskRise = w_wrMask ? (bus.wdata & ~r_mask & r_pending) : '0;
   assign w_fire     = (w_event & r_mask) | w_maskRise;
   assign w_req      = w_fire[3:0] | w_fire[7:4];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_srcPrev <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_rdata   <= '0;
         r_req     <= '0;
      end else begin
         r_srcPrev <= i_src;
         r_pending <= (r_pending & ~w_clear) | w_event;
         r_req     <= w_req;
         if (w_wrMask) begin
            r_mask <= bus.wdata;
         end
         if (bus.re) begin
            case (bus.addr)
               2'd0:    r_rdata <= r_pending;
               2'd1:    r_rdata <= r_mask;
               2'd2:    r_rdata <= r_pending & r_mask;
               default: r_rdata <= 8'h00;
            endcase
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_stateNext[k]  = r_state[k];
         w_cntNext[k]    = r_cnt[k];
         w_queuedNext[k] = r_queued[k];
         case (r_state[k])
            IDLE: begin
               if (r_req[k]) begin
                  w_stateNext[k] = HIGH;
                  w_cntNext[k]   = LOAD;
               end
            end
            HIGH: begin
               if (r_req[k]) begin
                  w_queuedNext[k] = 1'b1;
               end
               if (r_cnt[k] == '0) begin
                  w_stateNext[k] = GAP;
                  w_cntNext[k]   = LOAD;
               end else begin
                  w_cntNext[k] = r_cnt[k] - 1'b1;
               end
            end
            GAP: begin
               // A request landing on the final gap cycle starts the next pulse directly.
               if (r_cnt[k] == '0) begin
                  w_queuedNext[k] = 1'b0;
                  if (r_queued[k] || r_req[k]) begin
                     w_stateNext[k] = HIGH;
                     w_cntNext[k]   = LOAD;
                  end else begin
                     w_stateNext[k] = IDLE;
                  end
               end else begin
                  w_cntNext[k] = r_cnt[k] - 1'b1;
                  if (r_req[k]) begin
                     w_queuedNext[k] = 1'b1;
                  end
               end
            end
            default: begin
               w_stateNext[k] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= IDLE;
            r_cnt[k]   <= '0;
         end
         r_queued <= '0;
         r_int    <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            r_state[k] <= w_stateNext[k];
            r_cnt[k]   <= w_cntNext[k];
            r_int[k]   <= (w_stateNext[k] == HIGH);
         end
         r_queued <= w_queuedNext;
      end
   end

   assign bus.rdata = r_rdata;
   assign o_int1    = r_int[0];
   assign o_int2    = r_int[1];
   assign o_int3    = r_int[2];
   assign o_int4    = r_int[3];
endmodule
